pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset and lock supervisor that sits directly upstream of the PLL and the LED counter it clocks. It debounces the two push-button reset requests and sequences the PLL reset against the PLL lock indication. It holds the counter in reset until lock has been stable for a programmable settle time. It also counts lock-loss events and flags repeated lock timeouts.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive synchronized-stable cycles before a key level is accepted (20 ms at 50 MHz).
- RST_HOLD_CYCLES, 64: minimum pll_reset assertion length.
- LOCK_TIMEOUT, 500_000: cycles allowed in WAIT_LOCK before a retry.
- SETTLE_CYCLES, 1024: consecutive locked cycles required before RUN.
- MAX_RETRIES, 3: timeouts tolerated before FAULT.
- clk  in  1  free-running reference clock (CLOCK_50); sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  2  raw active-low buttons, asynchronous; [0] requests a PLL reset, [1] requests a counter reset.
- pll_locked  in  1  PLL lock output, asynchronous to clk.
- pll_reset  out  1  active-high PLL reset.
- counter_reset_n  out  1  active-low counter reset.
- state  out  3  current FSM state encoding.
- relock_count  out  8  lock losses seen in RUN; saturates at 255.
- timeout_err  out  1  sticky FAULT indicator.

## Operation
- Synchronizers:
  - key_n[1:0] and pll_locked each pass through a 2-flop synchronizer.
  - The synchronizer flops reset to key released (1) and unlocked (0).
  - The synchronized lock signal is lock_s.
- Debounce:
  - Each key has its own counter. A new level is accepted only after the synchronized level differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the accepted level clears that key's counter.
  - The accepted level resets to released. The debounced pressed signals are key0_p and key1_p.
- FSM states (encoding):
  - PLL_RST (0): pll_reset=1. A timer counts RST_HOLD_CYCLES cycles, then the FSM goes to WAIT_LOCK, but only if key0_p=0. Otherwise it holds in PLL_RST.
  - WAIT_LOCK (1): pll_reset=0. lock_s=1 goes to SETTLE. On a timer timeout (LOCK_TIMEOUT cycles), retry_cnt is incremented. If the new value equals MAX_RETRIES the FSM goes to FAULT; otherwise it goes to PLL_RST.
  - SETTLE (2): lock_s=0 goes to WAIT_LOCK with the timer restarted; this is not counted as a retry or a relock. SETTLE_CYCLES consecutive cycles with lock_s=1 go to RUN and clear retry_cnt.
  - RUN (3): lock_s=0 goes to PLL_RST and increments relock_count, saturating at 255.
  - FAULT (4): pll_reset=1 and timeout_err=1. Exit is only by key0_p=1, which goes to PLL_RST and clears timeout_err and retry_cnt.
- Priority:
  - key0_p=1 forces PLL_RST from any state and restarts the hold timer. This beats lock loss, timeout and settle completion in the same cycle.
  - A lock loss coincident with key0_p does not increment relock_count.
- counter_reset_n is 1 only in RUN with key1_p=0. key1_p never affects pll_reset or the FSM.
- The timer is a single shared counter, zeroed on every state entry. It is wide enough for the largest parameter.

## Timing
- Reset values: state=PLL_RST, pll_reset=1, counter_reset_n=0, relock_count=0, timeout_err=0, retry_cnt=0, all timers 0.
- Outputs are registered and are decoded from the next state. They change on the same edge as state, with no extra pipeline stage.
- Input latency:
  - pll_locked to lock_s: 2 edges.
  - lock_s to state change: 1 edge.
  - A key edge reaches key*_p after 2 + DEBOUNCE_CYCLES edges.
- Cycle counts from the first edge after reset deassertion (edge 1), with pll_locked held high and test parameters:
  - lock_s=1 at edge 2.
  - WAIT_LOCK at edge RST_HOLD_CYCLES.
  - SETTLE at edge RST_HOLD_CYCLES+1.
  - RUN and counter_reset_n=1 at edge RST_HOLD_CYCLES+1+SETTLE_CYCLES.
- An asynchronous reset mid-operation immediately returns every output to its reset value.

## Test plan
Test parameters for every scenario: DEBOUNCE=4, RST_HOLD=8, LOCK_TIMEOUT=32, SETTLE=16, MAX_RETRIES=3.
- pll_locked tied 1, keys released -> pll_reset falls at edge 8; state=SETTLE at edge 9; counter_reset_n rises at edge 25 with state=3.
- pll_locked tied 0 -> three cycles of PLL_RST(8)/WAIT_LOCK(32), then state=4, timeout_err=1, pll_reset=1, counter_reset_n=0 held indefinitely. A key0 hold of ≥6 cycles then returns the FSM to state 0 with timeout_err=0.
- A 3-cycle low glitch on pll_locked during SETTLE -> state returns to 1, then re-enters SETTLE. RUN arrives 16 cycles after the last re-entry; relock_count stays 0.
- In RUN, drop pll_locked -> 3 edges later state=0, counter_reset_n=0, relock_count=1. Repeating 300 times -> relock_count=255.
- In RUN, pulse key_n[1] low for 3 cycles -> no change. Hold it low for 10 cycles -> counter_reset_n=0 from edge 6 of the hold until 6 edges after release; pll_reset stays 0 and state stays 3.
- In RUN, hold key_n[0] low coincident with a pll_locked drop -> state=0, relock_count unchanged. pll_reset stays 1 until 8 cycles after key0_p clears.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the PLL and the counter it clocks: debounces the
// reset keys, sequences pll_reset against lock, and gates counter reset on settled lock.
module pll_reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RST_HOLD_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT    = 500_000,
    parameter int unsigned SETTLE_CYCLES   = 1024,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] key_n,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic       counter_reset_n,
    output logic [2:0] state,
    output logic [7:0] relock_count,
    output logic       timeout_err
);

    localparam int unsigned HOLD_MAX  = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TIMER_MAX = (HOLD_MAX > SETTLE_CYCLES) ? HOLD_MAX : SETTLE_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int unsigned DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    logic [1:0]         key_meta;
    logic [1:0]         key_sync;
    logic               lock_meta;
    logic               lock_s;

    logic [1:0]         key_p;
    logic [1:0]         key_p_nxt;
    logic [DEB_W-1:0]   deb_cnt [2];
    logic [DEB_W-1:0]   deb_nxt [2];
    logic               key0_p;
    logic               key1_p_nxt;

    state_t             state_q;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [RETRY_W-1:0] retry_inc;
    logic [7:0]         relock_nxt;

    assign key0_p     = key_p[0];
    assign key1_p_nxt = key_p_nxt[1];
    assign retry_inc  = retry_cnt + RETRY_W'(1);
    assign state      = state_q;

    // Two-flop synchronizers; idle levels are keys released and PLL unlocked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_meta  <= 2'b11;
            key_sync  <= 2'b11;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            key_meta  <= key_n;
            key_sync  <= key_meta;
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Per-key debounce: accept a new pressed level after it persists DEBOUNCE_CYCLES cycles.
    always_comb begin
        key_p_nxt = key_p;
        for (int i = 0; i < 2; i++) begin
            deb_nxt[i] = '0;
            if (!key_sync[i] != key_p[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    key_p_nxt[i] = !key_sync[i];
                end else begin
                    deb_nxt[i] = deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_p   <= 2'b00;
            deb_cnt <= '{default: '0};
        end else begin
            key_p   <= key_p_nxt;
            deb_cnt <= deb_nxt;
        end
    end

    // Next-state logic; key0_p overrides every other event in the same cycle.
    always_comb begin
        state_nxt  = state_q;
        retry_nxt  = retry_cnt;
        relock_nxt = relock_count;

        if (key0_p) begin
            state_nxt = S_PLL_RST;
            if (state_q == S_FAULT) begin
                retry_nxt = '0;
            end
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (timer >= HOLD_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_SETTLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_nxt = retry_inc;
                        state_nxt = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
                    end
                end
                S_SETTLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (timer == SETTLE_LAST) begin
                        state_nxt = S_RUN;
                        retry_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_PLL_RST;
                        if (relock_count != 8'hFF) begin
                            relock_nxt = relock_count + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_PLL_RST;
                end
            endcase
        end

        // Shared timer restarts on every state entry and on each key0 request.
        if (key0_p || (state_nxt != state_q)) begin
            timer_nxt = '0;
        end else if (timer == {TIMER_W{1'b1}}) begin
            timer_nxt = timer;
        end else begin
            timer_nxt = timer + TIMER_W'(1);
        end
    end

    // State and outputs share one register stage, outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_PLL_RST;
            timer           <= '0;
            retry_cnt       <= '0;
            relock_count    <= 8'd0;
            pll_reset       <= 1'b1;
            counter_reset_n <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            timer           <= timer_nxt;
            retry_cnt       <= retry_nxt;
            relock_count    <= relock_nxt;
            pll_reset       <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAULT);
            counter_reset_n <= (state_nxt == S_RUN) && !key1_p_nxt;
            timeout_err     <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector tables of {inputs, cycles, expected outputs}
// with expected records queued at drive time and popped when outputs are sampled.
module tb_pll_reset_sequencer;

    localparam int unsigned DEB    = 4;
    localparam int unsigned HOLD   = 8;
    localparam int unsigned TMO    = 32;
    localparam int unsigned SETTLE = 16;
    localparam int unsigned RETRY  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] key_n = 2'b11;
    logic       pll_locked = 1'b0;
    logic       pll_reset;
    logic       counter_reset_n;
    logic [2:0] state;
    logic [7:0] relock_count;
    logic       timeout_err;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .RST_HOLD_CYCLES(HOLD),
        .LOCK_TIMEOUT   (TMO),
        .SETTLE_CYCLES  (SETTLE),
        .MAX_RETRIES    (RETRY)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .key_n          (key_n),
        .pll_locked     (pll_locked),
        .pll_reset      (pll_reset),
        .counter_reset_n(counter_reset_n),
        .state          (state),
        .relock_count   (relock_count),
        .timeout_err    (timeout_err)
    );

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       pr;
        logic       crn;
        logic [7:0] rc;
        logic       te;
    } exp_t;

    typedef struct {
        string      name;
        logic [1:0] key_n;
        logic       locked;
        int         cycles;
        exp_t       exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(string name, logic [1:0] k, logic l, int cyc,
                                logic [2:0] st, logic pr, logic crn, logic [7:0] rc, logic te);
        vec_t v;
        v.name    = name;
        v.key_n   = k;
        v.locked  = l;
        v.cycles  = cyc;
        v.exp.name = name;
        v.exp.st  = st;
        v.exp.pr  = pr;
        v.exp.crn = crn;
        v.exp.rc  = rc;
        v.exp.te  = te;
        return v;
    endfunction

    task automatic check_field(string name, string field, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", name, field, act, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected a pending record");
        end else begin
            e = sb.pop_front();
            check_field(e.name, "state", int'(state), int'(e.st));
            check_field(e.name, "pll_reset", int'(pll_reset), int'(e.pr));
            check_field(e.name, "counter_reset_n", int'(counter_reset_n), int'(e.crn));
            check_field(e.name, "relock_count", int'(relock_count), int'(e.rc));
            check_field(e.name, "timeout_err", int'(timeout_err), int'(e.te));
        end
    endtask

    // Drive inputs at a falling edge, run the given rising edges, then compare.
    task automatic run_vec(vec_t v);
        key_n      = v.key_n;
        pll_locked = v.locked;
        sb.push_back(v.exp);
        repeat (v.cycles) @(negedge clk);
        compare_out();
    endtask

    task automatic run_table();
        foreach (tbl[i]) run_vec(tbl[i]);
        tbl.delete();
    endtask

    // Asserts reset away from the clock edge, checks the asynchronous return to
    // reset values, then releases at a falling edge so the next rising edge is edge 1.
    task automatic apply_reset(string name, logic locked);
        exp_t e;
        @(negedge clk);
        #2;
        key_n      = 2'b11;
        pll_locked = locked;
        reset_n    = 1'b0;
        #1;
        e.name = name; e.st = 3'd0; e.pr = 1'b1; e.crn = 1'b0; e.rc = 8'd0; e.te = 1'b0;
        sb.push_back(e);
        compare_out();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_rc;

        // Locked boot, key1 gating in RUN, lock loss and relock.
        apply_reset("reset_locked", 1'b1);
        tbl.push_back(mk("boot_e7",      2'b11, 1'b1,  7, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("boot_e8",      2'b11, 1'b1,  1, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("boot_e9",      2'b11, 1'b1,  1, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("boot_e24",     2'b11, 1'b1, 15, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("boot_e25",     2'b11, 1'b1,  1, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        tbl.push_back(mk("key1_pulse",   2'b01, 1'b1,  3, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        tbl.push_back(mk("key1_quiet",   2'b11, 1'b1, 10, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        tbl.push_back(mk("key1_hold5",   2'b01, 1'b1,  5, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        tbl.push_back(mk("key1_hold6",   2'b01, 1'b1,  1, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("key1_hold10",  2'b01, 1'b1,  4, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("key1_rel5",    2'b11, 1'b1,  5, 3'd3, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("key1_rel6",    2'b11, 1'b1,  1, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        tbl.push_back(mk("drop_e2",      2'b11, 1'b0,  2, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        tbl.push_back(mk("drop_e3",      2'b11, 1'b0,  1, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0));
        tbl.push_back(mk("relock_e24",   2'b11, 1'b1, 24, 3'd2, 1'b0, 1'b0, 8'd1, 1'b0));
        tbl.push_back(mk("relock_e25",   2'b11, 1'b1,  1, 3'd3, 1'b0, 1'b1, 8'd1, 1'b0));
        run_table();

        // key0 press with lock loss seen by the FSM on the same edge.
        run_vec(mk("k0_press",    2'b10, 1'b1,  4, 3'd3, 1'b0, 1'b1, 8'd1, 1'b0));
        run_vec(mk("k0_drop_e6",  2'b10, 1'b0,  2, 3'd3, 1'b0, 1'b1, 8'd1, 1'b0));
        run_vec(mk("k0_drop_e7",  2'b10, 1'b0,  1, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0));
        run_vec(mk("k0_held_e10", 2'b10, 1'b1,  3, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0));
        run_vec(mk("k0_rel_e23",  2'b11, 1'b1, 13, 3'd0, 1'b1, 1'b0, 8'd1, 1'b0));
        run_vec(mk("k0_rel_e24",  2'b11, 1'b1,  1, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0));
        run_vec(mk("k0_rel_e25",  2'b11, 1'b1,  1, 3'd2, 1'b0, 1'b0, 8'd1, 1'b0));
        run_vec(mk("k0_rel_e41",  2'b11, 1'b1, 16, 3'd3, 1'b0, 1'b1, 8'd1, 1'b0));

        // Repeated lock losses drive relock_count to saturation.
        for (int k = 1; k <= 300; k++) begin
            exp_rc = (k + 1 > 255) ? 255 : k + 1;
            run_vec(mk("relock_loop_drop", 2'b11, 1'b0,  3, 3'd0, 1'b1, 1'b0, 8'(exp_rc), 1'b0));
            run_vec(mk("relock_loop_run",  2'b11, 1'b1, 25, 3'd3, 1'b0, 1'b1, 8'(exp_rc), 1'b0));
        end

        // Asynchronous reset from RUN clears everything, including the saturated count.
        apply_reset("reset_mid_run", 1'b1);

        // Short lock glitch during SETTLE.
        tbl.push_back(mk("gl_e9",     2'b11, 1'b1,  9, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("gl_e12",    2'b11, 1'b1,  3, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("gl_low",    2'b11, 1'b0,  3, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("gl_wait",   2'b11, 1'b1,  2, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("gl_resettle", 2'b11, 1'b1, 1, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("gl_settle15", 2'b11, 1'b1, 15, 3'd2, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("gl_run",    2'b11, 1'b1,  1, 3'd3, 1'b0, 1'b1, 8'd0, 1'b0));
        run_table();

        // Never locks: three timeouts then FAULT, key0 recovery clears retries.
        apply_reset("reset_unlocked", 1'b0);
        tbl.push_back(mk("to_e8",     2'b11, 1'b0,  8, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("to_e39",    2'b11, 1'b0, 31, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("to_e40",    2'b11, 1'b0,  1, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("to_e48",    2'b11, 1'b0,  8, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("to_e80",    2'b11, 1'b0, 32, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("to_e119",   2'b11, 1'b0, 39, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("to_fault",  2'b11, 1'b0,  1, 3'd4, 1'b1, 1'b0, 8'd0, 1'b1));
        tbl.push_back(mk("to_hold",   2'b11, 1'b0, 50, 3'd4, 1'b1, 1'b0, 8'd0, 1'b1));
        tbl.push_back(mk("fault_k0_e6", 2'b10, 1'b0, 6, 3'd4, 1'b1, 1'b0, 8'd0, 1'b1));
        tbl.push_back(mk("fault_k0_e7", 2'b11, 1'b0, 1, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("fault_rel_e19", 2'b11, 1'b0, 12, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("fault_rel_e20", 2'b11, 1'b0, 1, 3'd1, 1'b0, 1'b0, 8'd0, 1'b0));
        tbl.push_back(mk("retry_clr_e52", 2'b11, 1'b0, 32, 3'd0, 1'b1, 1'b0, 8'd0, 1'b0));
        run_table();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
